// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: sends handshaked bytes as 11-bit frames on a
// self-generated PS/2 clock, backing off on host inhibit and request-to-send.
module ps2_device_tx #(
  parameter int unsigned HALF_PERIOD = 2500,
  parameter int unsigned IDLE_CYCLES = 2500
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_aborted,
  output logic       host_rts,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low
);

  typedef enum logic [2:0] {
    S_HOLDOFF,
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_TAIL
  } state_e;

  localparam logic [15:0] HP_LAST   = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);
  localparam logic [3:0]  STOP_IDX  = 4'd10;

  logic [1:0]  clk_sync_q, clk_sync_d;
  logic [1:0]  dat_sync_q, dat_sync_d;
  state_e      state_q, state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] hp_cnt_q, hp_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic        pending_q, pending_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        clk_low_q, clk_low_d;
  logic        dat_low_q, dat_low_d;

  logic        clk_s, dat_s, bus_idle, hp_last, accept;
  logic [10:0] frame_d;

  assign clk_s    = clk_sync_q[1];
  assign dat_s    = dat_sync_q[1];
  assign bus_idle = clk_s & dat_s;
  assign hp_last  = (hp_cnt_q == HP_LAST);

  // pending_q marks a byte the block owns until its frame completes, so an
  // aborted byte keeps the handshake closed and is resent automatically.
  assign tx_ready = (state_q == S_IDLE) & bus_idle & ~pending_q;
  assign accept   = tx_valid & tx_ready;
  assign host_rts = ((state_q == S_HOLDOFF) | (state_q == S_IDLE)) & clk_s & ~dat_s;

  assign tx_done           = done_q;
  assign tx_aborted        = aborted_q;
  assign ps2_clk_drive_low = clk_low_q;
  assign ps2_dat_drive_low = dat_low_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    clk_sync_d = {clk_sync_q[0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[0], ps2_dat_in};
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    hp_cnt_d   = hp_cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    parity_d   = parity_q;
    pending_d  = pending_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      S_HOLDOFF: begin
        if (!bus_idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          idle_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end

      S_IDLE: begin
        if (!bus_idle) begin
          idle_cnt_d = '0;
          state_d    = S_HOLDOFF;
        end else if (pending_q || accept) begin
          if (accept) begin
            data_d    = tx_data;
            parity_d  = ~^tx_data;
            pending_d = 1'b1;
          end
          idx_d    = '0;
          hp_cnt_d = '0;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          // A host holding the clock low before the stop bit is an inhibit.
          if (!clk_s && (idx_q != STOP_IDX)) begin
            aborted_d  = 1'b1;
            idle_cnt_d = '0;
            state_d    = S_HOLDOFF;
          end else begin
            state_d = S_LOW;
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 16'd1;
        end
      end

      S_LOW: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          if (idx_q == STOP_IDX) begin
            state_d = S_TAIL;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SETUP;
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 16'd1;
        end
      end

      S_TAIL: begin
        if (hp_last) begin
          hp_cnt_d   = '0;
          done_d     = 1'b1;
          pending_d  = 1'b0;
          idle_cnt_d = '0;
          state_d    = S_HOLDOFF;
        end else begin
          hp_cnt_d = hp_cnt_q + 16'd1;
        end
      end

      default: begin
        idle_cnt_d = '0;
        state_d    = S_HOLDOFF;
      end
    endcase

    // Line drivers are registered from the next state so they change on the
    // same edge as the state and never glitch on the open-drain pins.
    frame_d   = {1'b1, parity_d, data_d, 1'b0};
    clk_low_d = (state_d == S_LOW);
    dat_low_d = ((state_d == S_SETUP) || (state_d == S_LOW)) && !frame_d[idx_d];
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      // NOTE: synchronisers reset to 1 (released, pulled-up bus) so idle counting starts at once.
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      state_q    <= S_HOLDOFF;
      idle_cnt_q <= '0;
      hp_cnt_q   <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      hp_cnt_q   <= hp_cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      clk_low_q  <= clk_low_d;
      dat_low_q  <= dat_low_d;
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: emulated host on open-drain lines,
// frames checked against bit sequences derived from the byte value.
module tb_ps2_device_tx;

  localparam int HP   = 4;
  localparam int IDLE = 8;
  localparam int LAT  = 23 * HP;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_aborted, host_rts;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_drive_low, ps2_dat_drive_low;
  logic       host_clk_low = 1'b0;
  logic       host_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_drive_low | host_clk_low);
  assign ps2_dat_in = ~(ps2_dat_drive_low | host_dat_low);

  ps2_device_tx #(.HALF_PERIOD(HP), .IDLE_CYCLES(IDLE)) dut (
    .CLOCK_50          (CLOCK_50),
    .resetn            (resetn),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_done           (tx_done),
    .tx_aborted        (tx_aborted),
    .host_rts          (host_rts),
    .ps2_clk_in        (ps2_clk_in),
    .ps2_dat_in        (ps2_dat_in),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_dat_drive_low (ps2_dat_drive_low)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Results of the most recent transfer
  int          accept_cyc, done_cyc, n_done, n_abort, n_bits, n_pulses, bad_len;
  logic [10:0] got_bits;
  bit          ready_seen, both_seen, abort_drv, timed_out;

  // Expected line sequence: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_ready(output int gap);
    int  start;
    bit  seen;
    start = cyc;
    seen  = 0;
    gap   = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (tx_ready) begin
        seen = 1;
        gap  = cyc - start;
      end else begin
        @(negedge CLOCK_50);
      end
    end
  endtask

  // Offer byte b, then watch the bus as a host would until tx_done. If
  // inhib_at > 0 the host pulls the clock low for inhib_len cycles right after
  // the inhib_at-th device clock pulse ends.
  task automatic xfer(input logic [7:0] b, input int inhib_at, input int inhib_len);
    int hold, len, wait_n;
    bit prev, inhib_done;
    hold = 0; len = 0; wait_n = 0; inhib_done = 0;
    n_done = 0; n_abort = 0; n_bits = 0; n_pulses = 0; bad_len = 0;
    got_bits = '0; ready_seen = 0; both_seen = 0; abort_drv = 0; timed_out = 0;
    accept_cyc = 0; done_cyc = 0;
    @(negedge CLOCK_50);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && wait_n < 300) begin
      @(negedge CLOCK_50);
      wait_n++;
    end
    if (!tx_ready) begin
      tx_valid  = 1'b0;
      timed_out = 1;
      return;
    end
    @(negedge CLOCK_50);
    accept_cyc = cyc;
    tx_valid   = 1'b0;
    prev = ps2_clk_drive_low;
    for (int c = 0; c < 800 && n_done == 0; c++) begin
      @(negedge CLOCK_50);
      if (tx_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (tx_aborted) begin
        n_abort++;
        abort_drv = ps2_clk_drive_low | ps2_dat_drive_low;
        n_bits = 0; n_pulses = 0; bad_len = 0; got_bits = '0;
      end
      if (tx_done && tx_aborted) both_seen = 1;
      if (tx_ready) ready_seen = 1;
      if (hold > 0) begin
        hold--;
        if (hold == 0) host_clk_low = 1'b0;
      end
      if (ps2_clk_drive_low && !prev) begin
        if (n_bits < 11) got_bits[n_bits] = ps2_dat_in;
        n_bits++;
        len = 0;
      end
      if (ps2_clk_drive_low) len++;
      if (!ps2_clk_drive_low && prev) begin
        n_pulses++;
        if (len != HP) bad_len++;
        if (!inhib_done && inhib_at > 0 && n_pulses == inhib_at) begin
          host_clk_low = 1'b1;
          hold         = inhib_len;
          inhib_done   = 1;
        end
      end
      prev = ps2_clk_drive_low;
    end
    host_clk_low = 1'b0;
    if (n_done == 0) timed_out = 1;
  endtask

  task automatic test_reset();
    int gap;
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got %b exp 0", tx_ready); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got %b exp 0", tx_done); end
    checks++; if (tx_aborted !== 1'b0) begin errors++; $display("FAIL reset_tx_aborted got %b exp 0", tx_aborted); end
    checks++; if (host_rts !== 1'b0) begin errors++; $display("FAIL reset_host_rts got %b exp 0", host_rts); end
    checks++; if (ps2_clk_drive_low !== 1'b0) begin errors++; $display("FAIL reset_clk_drive got %b exp 0", ps2_clk_drive_low); end
    checks++; if (ps2_dat_drive_low !== 1'b0) begin errors++; $display("FAIL reset_dat_drive got %b exp 0", ps2_dat_drive_low); end
    resetn = 1'b1;
    wait_ready(gap);
    checks++; if (gap !== IDLE) begin errors++; $display("FAIL reset_idle_gap got %0d exp %0d", gap, IDLE); end
  endtask

  task automatic test_basic();
    xfer(8'h1C, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got timeout exp done"); end
    checks++; if (got_bits !== 11'b100_0011_1000) begin errors++; $display("FAIL basic_bits got %b exp %b", got_bits, 11'b100_0011_1000); end
    checks++; if (n_pulses !== 11 || bad_len !== 0) begin errors++; $display("FAIL basic_pulses got %0d pulses %0d bad widths exp 11 and 0", n_pulses, bad_len); end
    checks++; if (done_cyc - accept_cyc !== LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", done_cyc - accept_cyc, LAT); end
    checks++; if (ready_seen || n_abort !== 0) begin errors++; $display("FAIL basic_quiet got ready %0b aborts %0d exp 0 and 0", ready_seen, n_abort); end
  endtask

  task automatic test_parity();
    int gap;
    xfer(8'hF0, 0, 0);
    checks++; if (got_bits !== frame_of(8'hF0)) begin errors++; $display("FAIL parity_bits got %b exp %b", got_bits, frame_of(8'hF0)); end
    checks++; if (got_bits[10:9] !== 2'b11) begin errors++; $display("FAIL parity_stop got %b exp 11", got_bits[10:9]); end
    checks++; if (done_cyc - accept_cyc !== LAT) begin errors++; $display("FAIL parity_latency got %0d exp %0d", done_cyc - accept_cyc, LAT); end
    wait_ready(gap);
    checks++; if (gap !== IDLE) begin errors++; $display("FAIL parity_ready_gap got %0d exp %0d", gap, IDLE); end
  endtask

  task automatic test_inhibit();
    xfer(8'h55, 5, 20);
    checks++; if (timed_out) begin errors++; $display("FAIL inhibit_timeout got timeout exp done"); end
    checks++; if (n_abort !== 1) begin errors++; $display("FAIL inhibit_aborts got %0d exp 1", n_abort); end
    checks++; if (abort_drv !== 1'b0) begin errors++; $display("FAIL inhibit_release got %b exp 0", abort_drv); end
    checks++; if (n_done !== 1 || both_seen) begin errors++; $display("FAIL inhibit_done got %0d both %0b exp 1 and 0", n_done, both_seen); end
    checks++; if (got_bits !== frame_of(8'h55) || n_pulses !== 11) begin errors++; $display("FAIL inhibit_resend got %b/%0d exp %b/11", got_bits, n_pulses, frame_of(8'h55)); end
    checks++; if (ready_seen) begin errors++; $display("FAIL inhibit_ready got 1 exp 0 until resend done"); end
  endtask

  task automatic test_late_inhibit();
    logic [7:0] b;
    b = 8'($urandom);
    xfer(b, 10, 6);
    checks++; if (n_abort !== 0) begin errors++; $display("FAIL late_aborts got %0d exp 0", n_abort); end
    checks++; if (done_cyc - accept_cyc !== LAT) begin errors++; $display("FAIL late_latency got %0d exp %0d", done_cyc - accept_cyc, LAT); end
    checks++; if (got_bits !== frame_of(b)) begin errors++; $display("FAIL late_bits got %b exp %b", got_bits, frame_of(b)); end
  endtask

  task automatic test_host_rts();
    int gap, bad, acc, dn;
    bit seen;
    logic [7:0] b;
    b = 8'($urandom);
    wait_ready(gap);
    @(negedge CLOCK_50);
    host_dat_low = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLOCK_50);
      seen = host_rts;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rts_detect got 0 exp 1"); end
    tx_data  = b;
    tx_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (tx_ready || !host_rts || ps2_clk_drive_low || ps2_dat_drive_low) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rts_hold got %0d bad cycles exp 0", bad); end
    host_dat_low = 1'b0;
    wait_ready(gap);
    checks++; if (gap !== IDLE + 2) begin errors++; $display("FAIL rts_release_gap got %0d exp %0d", gap, IDLE + 2); end
    checks++; if (host_rts !== 1'b0) begin errors++; $display("FAIL rts_clear got %b exp 0", host_rts); end
    @(negedge CLOCK_50);
    acc = cyc;
    tx_valid = 1'b0;
    checks++; if (ps2_dat_drive_low !== 1'b1 || tx_ready !== 1'b0) begin errors++; $display("FAIL rts_accept got drive %b ready %b exp 1 0", ps2_dat_drive_low, tx_ready); end
    dn = -1;
    for (int i = 0; i < 300 && dn < 0; i++) begin
      @(negedge CLOCK_50);
      if (tx_done) dn = cyc - acc;
    end
    checks++; if (dn !== LAT) begin errors++; $display("FAIL rts_latency got %0d exp %0d", dn, LAT); end
  endtask

  task automatic test_reset_mid();
    int gap, pulses, stray;
    bit prev;
    wait_ready(gap);
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    pulses = 0;
    prev   = ps2_clk_drive_low;
    for (int i = 0; i < 200 && pulses < 3; i++) begin
      @(negedge CLOCK_50);
      if (!ps2_clk_drive_low && prev) pulses++;
      prev = ps2_clk_drive_low;
    end
    repeat (5) @(negedge CLOCK_50);
    checks++; if (ps2_clk_drive_low !== 1'b1) begin errors++; $display("FAIL midrst_in_bit3 got %b exp 1", ps2_clk_drive_low); end
    resetn = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (ps2_clk_drive_low !== 1'b0 || ps2_dat_drive_low !== 1'b0) begin errors++; $display("FAIL midrst_release got %b%b exp 00", ps2_clk_drive_low, ps2_dat_drive_low); end
    stray = 0;
    repeat (2) begin
      @(negedge CLOCK_50);
      if (tx_done || tx_aborted) stray++;
    end
    resetn = 1'b1;
    wait_ready(gap);
    checks++; if (gap !== IDLE) begin errors++; $display("FAIL midrst_ready_gap got %0d exp %0d", gap, IDLE); end
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (tx_done || tx_aborted || ps2_clk_drive_low || ps2_dat_drive_low) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_discard got %0d stray cycles exp 0", stray); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      xfer(b, 0, 0);
      checks++;
      if (got_bits !== frame_of(b) || done_cyc - accept_cyc !== LAT || n_abort !== 0 || timed_out) begin
        errors++;
        $display("FAIL random_frame byte %h got %b lat %0d exp %b lat %0d", b, got_bits, done_cyc - accept_cyc, frame_of(b), LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_inhibit();
    test_late_inhibit();
    test_host_rts();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
